c1_bus_master: RTL and testbench

C1_BUS_MASTER -- requirements
Module: c1_bus_master

---
 rtl/c1_bus_master.sv | 242 ++++++++++++++++++++++++
 tb/tb_c1_bus_master.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/c1_bus_master.sv
// c1_bus_master: round-robin master that serialises two requesters onto the C1 CPU-to-cache bus.
// Each command goes out as ADDR1/ADDR2 phases; the bus is then released until the cache answers or the wait times out.
module c1_bus_master #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  input  logic [5:0]  req_cmd,
  input  logic [37:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic [1:0]  req_ready,
  output logic [1:0]  rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        grant,
  output logic        busy,
  output logic [14:0] a1,
  inout  wire  [15:0] d1,
  inout  wire  [2:0]  c1
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR1 = 3'd1,
    ST_ADDR2 = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP2 = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [2:0] CMD_NOP  = 3'd0;
  localparam logic [2:0] CMD_RD8  = 3'd1;
  localparam logic [2:0] CMD_RD16 = 3'd2;
  localparam logic [2:0] CMD_RD32 = 3'd3;
  localparam logic [2:0] CMD_INV  = 3'd4;
  localparam logic [2:0] CMD_WR8  = 3'd5;
  localparam logic [2:0] CMD_WR16 = 3'd6;
  localparam logic [2:0] CMD_WR32 = 3'd7;
  localparam logic [2:0] C1_RESP  = 3'd7;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  function automatic logic is_write(input logic [2:0] cmd);
    return (cmd == CMD_WR8) || (cmd == CMD_WR16) || (cmd == CMD_WR32);
  endfunction

  function automatic logic [15:0] write_lo(input logic [2:0] cmd, input logic [31:0] wdata);
    if (cmd == CMD_WR8) begin
      return {8'd0, wdata[7:0]};
    end else begin
      return wdata[15:0];
    end
  endfunction

  state_t      state_r, state_nxt_s;
  logic        ptr_r, grant_r, err_r, busy_r, rsp_err_r;
  logic [1:0]  rsp_valid_r;
  logic [2:0]  cmd_r;
  logic [18:0] addr_r;
  logic [31:0] wdata_r, rdata_r;
  logic [7:0]  cnt_r;

  logic        win_s, accept_s;
  logic [2:0]  win_cmd_s, cur_cmd_s;
  logic [18:0] win_addr_s, cur_addr_s;
  logic [31:0] win_wdata_s, cur_wdata_s;

  logic        a1_oe_r, d1_oe_r, c1_oe_r;
  logic [14:0] a1_out_r;
  logic [15:0] d1_out_r;
  logic [2:0]  c1_out_r;
  logic        a1_oe_nxt_s, d1_oe_nxt_s, c1_oe_nxt_s;
  logic [14:0] a1_nxt_s;
  logic [15:0] d1_nxt_s;
  logic [2:0]  c1_nxt_s;

  // Round-robin winner selection and the accept handshake (must be same-cycle to pair with req_valid)
  always_comb begin
    win_s = 1'b0;
    if (req_valid == 2'b11) begin
      win_s = ptr_r;
    end else if (req_valid[1]) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
    accept_s    = rst_n && (state_r == ST_IDLE) && (|req_valid);
    win_cmd_s   = win_s ? req_cmd[5:3]     : req_cmd[2:0];
    win_addr_s  = win_s ? req_addr[37:19]  : req_addr[18:0];
    win_wdata_s = win_s ? req_wdata[63:32] : req_wdata[31:0];
    cur_cmd_s   = accept_s ? win_cmd_s   : cmd_r;
    cur_addr_s  = accept_s ? win_addr_s  : addr_r;
    cur_wdata_s = accept_s ? win_wdata_s : wdata_r;
    if (accept_s) begin
      req_ready = win_s ? 2'b10 : 2'b01;
    end else begin
      req_ready = 2'b00;
    end
  end

  // Next-state logic; only an exact 3'b111 on c1 counts as a cache response
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = (win_cmd_s == CMD_NOP) ? ST_DONE : ST_ADDR1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ADDR1: state_nxt_s = (cmd_r == CMD_INV) ? ST_WAIT : ST_ADDR2;
      ST_ADDR2: state_nxt_s = ST_WAIT;
      ST_WAIT: begin
        if (c1 == C1_RESP) begin
          state_nxt_s = (cmd_r == CMD_RD32) ? ST_RESP2 : ST_DONE;
        end else if (cnt_r == TMO_LAST) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_RESP2: state_nxt_s = ST_DONE;
      ST_DONE:  state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Bus drive values for the upcoming state, so pins change on the same edge as the FSM
  always_comb begin
    a1_oe_nxt_s = 1'b0;
    a1_nxt_s    = 15'd0;
    d1_oe_nxt_s = 1'b0;
    d1_nxt_s    = 16'd0;
    c1_oe_nxt_s = 1'b0;
    c1_nxt_s    = CMD_NOP;
    case (state_nxt_s)
      ST_IDLE, ST_DONE: c1_oe_nxt_s = 1'b1;
      ST_ADDR1: begin
        c1_oe_nxt_s = 1'b1;
        c1_nxt_s    = cur_cmd_s;
        a1_oe_nxt_s = 1'b1;
        a1_nxt_s    = cur_addr_s[18:4];
        d1_oe_nxt_s = is_write(cur_cmd_s);
        d1_nxt_s    = write_lo(cur_cmd_s, cur_wdata_s);
      end
      ST_ADDR2: begin
        c1_oe_nxt_s = 1'b1;
        c1_nxt_s    = cur_cmd_s;
        a1_oe_nxt_s = 1'b1;
        a1_nxt_s    = {11'd0, cur_addr_s[3:0]};
        d1_oe_nxt_s = is_write(cur_cmd_s);
        if (cur_cmd_s == CMD_WR32) begin
          d1_nxt_s = cur_wdata_s[31:16];
        end else begin
          d1_nxt_s = write_lo(cur_cmd_s, cur_wdata_s);
        end
      end
      ST_WAIT, ST_RESP2: c1_oe_nxt_s = 1'b0;
      default: c1_oe_nxt_s = 1'b1;
    endcase
  end

  // FSM state, bus drivers and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      busy_r      <= 1'b0;
      rsp_valid_r <= 2'b00;
      rsp_err_r   <= 1'b0;
      a1_oe_r     <= 1'b0;
      a1_out_r    <= 15'd0;
      d1_oe_r     <= 1'b0;
      d1_out_r    <= 16'd0;
      c1_oe_r     <= 1'b1;
      c1_out_r    <= CMD_NOP;
    end else begin
      state_r     <= state_nxt_s;
      busy_r      <= (state_nxt_s != ST_IDLE);
      rsp_valid_r <= (state_r == ST_DONE) ? (grant_r ? 2'b10 : 2'b01) : 2'b00;
      rsp_err_r   <= (state_r == ST_DONE) ? err_r : 1'b0;
      a1_oe_r     <= a1_oe_nxt_s;
      a1_out_r    <= a1_nxt_s;
      d1_oe_r     <= d1_oe_nxt_s;
      d1_out_r    <= d1_nxt_s;
      c1_oe_r     <= c1_oe_nxt_s;
      c1_out_r    <= c1_nxt_s;
    end
  end

  // Arbitration pointer, command latch, wait counter and response capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r   <= 1'b0;
      grant_r <= 1'b0;
      cmd_r   <= CMD_NOP;
      addr_r  <= 19'd0;
      wdata_r <= 32'd0;
      rdata_r <= 32'd0;
      err_r   <= 1'b0;
      cnt_r   <= 8'd0;
    end else begin
      if (accept_s) begin
        ptr_r   <= ~win_s;
        grant_r <= win_s;
        cmd_r   <= win_cmd_s;
        addr_r  <= win_addr_s;
        wdata_r <= win_wdata_s;
        err_r   <= 1'b0;
        if (win_cmd_s == CMD_NOP) begin
          rdata_r <= 32'd0;
        end
      end
      cnt_r <= (state_r == ST_WAIT) ? cnt_r + 8'd1 : 8'd0;
      if (state_r == ST_WAIT) begin
        if (c1 == C1_RESP) begin
          case (cmd_r)
            CMD_RD8:  rdata_r <= {24'd0, d1[7:0]};
            CMD_RD16: rdata_r <= {16'd0, d1};
            CMD_RD32: rdata_r[15:0] <= d1;
            default:  rdata_r <= rdata_r;
          endcase
        end else if (cnt_r == TMO_LAST) begin
          err_r <= 1'b1;
        end
      end
      if (state_r == ST_RESP2) begin
        rdata_r[31:16] <= d1;
      end
    end
  end

  assign a1        = a1_oe_r ? a1_out_r : 15'bz;
  assign d1        = d1_oe_r ? d1_out_r : 16'bz;
  assign c1        = c1_oe_r ? c1_out_r : 3'bz;
  assign rsp_valid = rsp_valid_r;
  assign rsp_err   = rsp_err_r;
  assign rsp_rdata = rdata_r;
  assign grant     = grant_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_c1_bus_master.sv
// tb_c1_bus_master: directed bench for c1_bus_master with a scripted cache on d1/c1.
// Expected bus phases and results are hand-computed per transaction.
module tb_c1_bus_master;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [5:0]  req_cmd;
  logic [37:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_ready, rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err, grant, busy;
  logic [14:0] a1;
  wire  [15:0] d1;
  wire  [2:0]  c1;
  logic        cache_d1_en, cache_c1_en;
  logic [15:0] cache_d1;
  logic [2:0]  cache_c1;
  int          n_tests, n_fail;

  assign d1 = cache_d1_en ? cache_d1 : 16'bz;
  assign c1 = cache_c1_en ? cache_c1 : 3'bz;

  always #5 clk = ~clk;

  c1_bus_master #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_cmd(req_cmd),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .grant(grant), .busy(busy), .a1(a1), .d1(d1), .c1(c1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Released line: reads as unknown/Z in a 4-state simulator, as 0 in a 2-state one.
  function automatic logic rel(input logic [15:0] v);
    return $isunknown(v) || (v == 16'd0);
  endfunction

  function automatic logic bus_released();
    return rel({1'b0, a1}) && rel(d1) && rel({13'd0, c1});
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input string name, input int idx, input logic [2:0] cmd,
                     input logic [18:0] addr, input logic [31:0] wdata,
                     input logic [14:0] ea1a, input logic [15:0] ed1a,
                     input logic [14:0] ea1b, input logic [15:0] ed1b, input logic edrv,
                     input int resp_at, input int noise_at,
                     input logic [15:0] dlo, input logic [15:0] dhi,
                     input logic [31:0] erdata, input logic eerr);
    logic [1:0] oh;
    int nwait;
    oh = (idx == 1) ? 2'b10 : 2'b01;
    req_cmd[idx*3 +: 3]    = cmd;
    req_addr[idx*19 +: 19] = addr;
    req_wdata[idx*32 +: 32] = wdata;
    req_valid[idx] = 1'b1;
    #1;
    check({name, "_ready"}, {30'd0, req_ready}, {30'd0, oh});
    step();
    req_valid[idx] = 1'b0;
    check({name, "_busy"}, {31'd0, busy}, 32'd1);
    check({name, "_no_ready"}, {30'd0, req_ready}, 32'd0);
    check({name, "_grant"}, {31'd0, grant}, idx);
    if (cmd == 3'd0) begin
      check({name, "_nop_c1"}, {29'd0, c1}, 32'd0);
    end else begin
      check({name, "_a1_c1"}, {29'd0, c1}, {29'd0, cmd});
      check({name, "_a1_a1"}, {17'd0, a1}, {17'd0, ea1a});
      if (edrv) check({name, "_a1_d1"}, {16'd0, d1}, {16'd0, ed1a});
      else      check({name, "_a1_d1z"}, {31'd0, rel(d1)}, 32'd1);
      step();
      if (cmd != 3'd4) begin
        check({name, "_a2_c1"}, {29'd0, c1}, {29'd0, cmd});
        check({name, "_a2_a1"}, {17'd0, a1}, {17'd0, ea1b});
        if (edrv) check({name, "_a2_d1"}, {16'd0, d1}, {16'd0, ed1b});
        else      check({name, "_a2_d1z"}, {31'd0, rel(d1)}, 32'd1);
        step();
      end
      nwait = (resp_at == 0) ? TMO : resp_at;
      for (int n = 1; n <= nwait; n++) begin
        cache_c1_en = 1'b0;
        cache_d1_en = 1'b0;
        #1;
        check({name, "_wait_z"}, {31'd0, bus_released()}, 32'd1);
        if (n == resp_at || n == noise_at) begin
          cache_c1    = (n == resp_at) ? 3'd7 : 3'd6;
          cache_d1    = (n == resp_at) ? dlo : 16'hFFFF;
          cache_c1_en = 1'b1;
          cache_d1_en = 1'b1;
        end
        step();
      end
      cache_c1_en = 1'b0;
      if (resp_at != 0 && cmd == 3'd3) begin
        cache_d1 = dhi;
        step();
      end
      cache_d1_en = 1'b0;
      #1;
    end
    check({name, "_done_c1"}, {29'd0, c1}, 32'd0);
    check({name, "_done_novalid"}, {30'd0, rsp_valid}, 32'd0);
    step();
    check({name, "_rsp_valid"}, {30'd0, rsp_valid}, {30'd0, oh});
    check({name, "_rsp_err"}, {31'd0, rsp_err}, {31'd0, eerr});
    if (cmd <= 3'd3 && !eerr) check({name, "_rdata"}, rsp_rdata, erdata);
    check({name, "_idle"}, {31'd0, busy}, 32'd0);
    step();
    check({name, "_pulse"}, {30'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail = 0;
    rst_n = 1'b0;
    req_valid = 2'b11;
    req_cmd = 6'd0;
    req_addr = 38'd0;
    req_wdata = 64'd0;
    cache_c1_en = 1'b0;
    cache_d1_en = 1'b0;
    cache_c1 = 3'd0;
    cache_d1 = 16'd0;
    #12;
    check("rst_ready", {30'd0, req_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_grant", {31'd0, grant}, 32'd0);
    check("rst_rsp", {29'd0, rsp_valid, rsp_err}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_c1", {29'd0, c1}, 32'd0);
    check("rst_a1d1z", {31'd0, rel({1'b0, a1}) && rel(d1)}, 32'd1);
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    step();

    txn("rd8", 0, 3'd1, 19'h00013, 32'd0, 15'h0001, 16'd0, 15'h0003, 16'd0, 1'b0,
        4, 0, 16'h12AB, 16'd0, 32'h000000AB, 1'b0);
    txn("nop", 1, 3'd0, 19'h00000, 32'd0, 15'd0, 16'd0, 15'd0, 16'd0, 1'b0,
        0, 0, 16'd0, 16'd0, 32'h00000000, 1'b0);
    txn("wr32", 1, 3'd7, 19'h40020, 32'hDEADBEEF, 15'h4002, 16'hBEEF, 15'h0000, 16'hDEAD, 1'b1,
        1, 0, 16'd0, 16'd0, 32'd0, 1'b0);
    txn("rd16", 0, 3'd2, 19'h7FFFF, 32'd0, 15'h7FFF, 16'd0, 15'h000F, 16'd0, 1'b0,
        2, 0, 16'hCAFE, 16'd0, 32'h0000CAFE, 1'b0);
    txn("rd32", 1, 3'd3, 19'h12345, 32'd0, 15'h1234, 16'd0, 15'h0005, 16'd0, 1'b0,
        1, 0, 16'h5678, 16'h1234, 32'h12345678, 1'b0);
    txn("wr8", 0, 3'd5, 19'h00100, 32'h123456A5, 15'h0010, 16'h00A5, 15'h0000, 16'h00A5, 1'b1,
        3, 0, 16'd0, 16'd0, 32'd0, 1'b0);
    txn("wr16", 1, 3'd6, 19'h00ABC, 32'hFFFF8001, 15'h00AB, 16'h8001, 15'h000C, 16'h8001, 1'b1,
        2, 0, 16'd0, 16'd0, 32'd0, 1'b0);
    txn("inv", 0, 3'd4, 19'h55550, 32'd0, 15'h5555, 16'd0, 15'd0, 16'd0, 1'b0,
        3, 0, 16'd0, 16'd0, 32'd0, 1'b0);
    txn("tmo", 1, 3'd1, 19'h00001, 32'd0, 15'h0000, 16'd0, 15'h0001, 16'd0, 1'b0,
        0, 2, 16'd0, 16'd0, 32'd0, 1'b1);

    // Reset in the middle of a WAIT phase; rsp_rdata still holds the READ32 result here.
    req_cmd[2:0] = 3'd1;
    req_addr[18:0] = 19'h00000;
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    step();
    step();
    step();
    check("mid_busy", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_grant", {31'd0, grant}, 32'd0);
    check("arst_rsp", {29'd0, rsp_valid, rsp_err}, 32'd0);
    check("arst_rdata", rsp_rdata, 32'd0);
    check("arst_c1", {29'd0, c1}, 32'd0);
    check("arst_a1d1z", {31'd0, rel({1'b0, a1}) && rel(d1)}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_quiet", {29'd0, rsp_valid, busy}, 32'd0);
    end

    // Both requesters continuously valid with NOPs: round-robin from a reset pointer.
    req_cmd = 6'd0;
    req_valid = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      check("rr_ready", {30'd0, req_ready}, (k % 2 == 0) ? 32'd1 : 32'd2);
      step();
      check("rr_busy_noready", {29'd0, busy, req_ready}, 32'd4);
      check("rr_grant", {31'd0, grant}, k % 2);
      step();
      check("rr_rsp", {30'd0, rsp_valid}, (k % 2 == 0) ? 32'd1 : 32'd2);
    end
    req_valid = 2'b00;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
